spi_target_regs: RTL and testbench
==================================

// Module: spi_target_regs
// PURPOSE
//  SPI responder (mode 0, MSB first) in FPGA fabric, answering the Nios spi0 master.
//  Presents 32 x 8-bit registers using a MAX3421E-style command byte, so the same
//  driver code can talk to fabric logic (game state, debug) instead of the USB chip.
//  The fabric side gets a registered read/write port plus a strobe on every SPI write.
// PARAMETERS
//  NREGS        32    register count; address width 5, fixed by the command format
//  STATUS_ADDR  0     register whose value is shifted out during the command byte
//  RESET_VAL    8'h00 reset value of every register
// PORTS
//  clk_clk      in   1  system clock; must be >= 8x SCLK
//  reset_reset  in   1  synchronous, active-high reset
//  spi_sclk     in   1  SPI clock from master (asynchronous to clk_clk)
//  spi_mosi     in   1  master-out data
//  spi_ss_n     in   1  active-low select
//  spi_miso     out  1  responder-out data
//  spi_miso_oe  out  1  MISO output enable; high only while selected
//  fab_addr     in   5  fabric register address
//  fab_wdata    in   8  fabric write data
//  fab_we       in   1  fabric write enable
//  fab_rdata    out  8  reg[fab_addr], registered (1-cycle latency)
//  spi_wr_stb   out  1  one-cycle pulse per SPI-written data byte
//  spi_wr_addr  out  5  address of that write
//  spi_wr_data  out  8  data of that write
// BEHAVIOUR
//  Reset: all regs = RESET_VAL. Outputs spi_miso=0, spi_miso_oe=0, fab_rdata=0,
//   spi_wr_stb=0, spi_wr_addr=0, spi_wr_data=0. FSM in IDLE, bit counter 0.
//  Inputs: 2-FF synchronisers on sclk/mosi/ss_n, then rise/fall detect on synced sclk.
//  Command byte: bits[7:3] = reg address, bit1 = 1 write / 0 read, bits 2,0 ignored.
//  FSM: IDLE -(ss_n low)-> CMD -(8th rise)-> DATA; any state -(ss_n high)-> IDLE.
//   In IDLE the bit counter clears and any partial byte is discarded (no write, no strobe).
//  MOSI is sampled on synced SCLK rise. MISO shifts on synced fall.
//  On entering CMD, the MISO shifter loads reg[STATUS_ADDR] and MSB drives immediately.
//  DATA read: on the 8th rise of each byte, load reg[addr] and drive its MSB at once.
//   addr then increments mod 32 for the next byte.
//  DATA write: on the 8th rise, reg[addr] <= byte and spi_wr_stb pulses for one cycle
//   with spi_wr_addr/data. addr then increments mod 32. MISO returns 8'h00.
//  Bit counter is 3 bits and wraps 7->0. Bursts of any length are legal.
//  Collision: SPI write and fab_we to the same address in the same cycle -> SPI value wins.
//   Different addresses -> both writes take effect.
//  fab_rdata: next cycle shows the register value after that cycle's writes.
//  spi_miso_oe = ~synced ss_n. spi_miso = 0 whenever oe=0.
//  Reset mid-transfer: immediate return to reset state; the SPI byte in flight is lost.
// STRUCTURE
//  Package spi_target_pkg holds:
//   - CMD_ADDR_MSB=7, CMD_ADDR_LSB=3, CMD_WR_BIT=1
//   - state enum {IDLE, CMD, DATA}
//   - NREGS and address width
//  Sub-module spi_sync_edge (2-FF sync + rise/fall detect) is instantiated for sclk,
//   and reused without edge outputs for mosi and ss_n.
//  Register file is flops (32x8), not RAM: single-cycle SPI/fabric access needed.
// TESTING
//  1 Reset, then fab_addr=0 -> fab_rdata=8'h00 next cycle; oe=0, miso=0, stb=0.
//  2 Fabric write reg0=8'hA5, SPI cmd 8'h10 (read reg2, reg2 preloaded 8'h3C)
//    -> MISO shows A5 during cmd, 3C during data byte.
//  3 SPI write cmd 8'h2A + data 8'h11,8'h22 -> reg5=11, reg6=22; two stb pulses
//    (addr 5, 6); fab_rdata at addr 6 = 22.
//  4 Write burst from addr 31 (cmd 8'hFA) data 8'h01,8'h02 -> reg31=01, reg0=02 (wrap).
//  5 Raise ss_n after 4 bits of a data byte -> no reg change, no stb; next transfer
//    starts in CMD correctly.
//  6 SPI write reg3=8'h77 in the same cycle as fab_we reg3=8'h55 -> reg3=77. Repeat with
//    fab_we to reg4 -> reg3=77, reg4=55.

Source files
------------

// File: rtl/spi_target_pkg.sv
// ============================================================================
// Module      : spi_target_pkg
// Description : Shared constants and FSM state type for the SPI register target.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_target_pkg;

    localparam int NREGS        = 32;
    localparam int ADDR_W       = 5;

    // Command byte layout: [7:3] register address, [1] write flag
    localparam int CMD_ADDR_MSB = 7;
    localparam int CMD_ADDR_LSB = 3;
    localparam int CMD_WR_BIT   = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/spi_sync_edge.sv
// ============================================================================
// Module      : spi_sync_edge
// Description : Two-flop synchroniser with rise/fall detection on the synced level.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_din,
    output logic o_dout,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
            r_prev <= RST_VAL;
        end else begin
            r_meta <= i_din;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_dout = r_sync;
    assign o_rise = r_sync & ~r_prev;
    assign o_fall = ~r_sync & r_prev;

endmodule

`default_nettype wire

// File: rtl/spi_target_regs.sv
// ============================================================================
// Module      : spi_target_regs
// Description : SPI mode-0 responder exposing 32 x 8-bit registers with a
//               MAX3421E-style command byte, plus a fabric read/write port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_target_regs
    import spi_target_pkg::*;
#(
    parameter logic [ADDR_W-1:0] STATUS_ADDR = '0,
    parameter logic [7:0]        RESET_VAL   = 8'h00
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic              spi_sclk,
    input  logic              spi_mosi,
    input  logic              spi_ss_n,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    input  logic [ADDR_W-1:0] fab_addr,
    input  logic [7:0]        fab_wdata,
    input  logic              fab_we,
    output logic [7:0]        fab_rdata,
    output logic              spi_wr_stb,
    output logic [ADDR_W-1:0] spi_wr_addr,
    output logic [7:0]        spi_wr_data
);

    logic w_sclk_rise, w_sclk_fall, w_sclk_lvl;
    logic w_mosi, w_mosi_rise, w_mosi_fall;
    logic w_ss_n, w_ss_rise, w_ss_fall;
    logic w_unused_edges;

    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk_clk), .rst(reset_reset), .i_din(spi_sclk),
        .o_dout(w_sclk_lvl), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk_clk), .rst(reset_reset), .i_din(spi_mosi),
        .o_dout(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
    );

    // ss_n resets high so the bus looks deselected straight out of reset
    spi_sync_edge #(.RST_VAL(1'b1)) u_sync_ss (
        .clk(clk_clk), .rst(reset_reset), .i_din(spi_ss_n),
        .o_dout(w_ss_n), .o_rise(w_ss_rise), .o_fall(w_ss_fall)
    );

    assign w_unused_edges = w_sclk_lvl | w_mosi_rise | w_mosi_fall | w_ss_rise | w_ss_fall;

    state_t            r_state, w_state_next;
    logic [2:0]        r_bit_cnt;
    logic [6:0]        r_shift_in;
    logic [7:0]        r_miso_sh;
    logic [ADDR_W-1:0] r_addr;
    logic              r_wr;
    logic [7:0]        r_regs [NREGS];
    logic [7:0]        r_fab_rdata;
    logic              r_wr_stb;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [7:0]        r_wr_data;

    logic [7:0]        w_byte;
    logic              w_byte_done;
    logic              w_spi_we;
    logic [ADDR_W-1:0] w_addr_next;
    logic [ADDR_W-1:0] w_cmd_addr;

    assign w_byte      = {r_shift_in, w_mosi};
    assign w_byte_done = w_sclk_rise && (r_bit_cnt == 3'd7) && !w_ss_n && (r_state != IDLE);
    assign w_spi_we    = w_byte_done && (r_state == DATA) && r_wr;
    assign w_addr_next = r_addr + 1'b1;
    assign w_cmd_addr  = w_byte[CMD_ADDR_MSB:CMD_ADDR_LSB];

    always_ff @(posedge clk_clk) begin
        if (reset_reset) r_state <= IDLE;
        else             r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (w_ss_n) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    w_state_next = CMD;
                CMD:     if (w_byte_done) w_state_next = DATA;
                DATA:    w_state_next = DATA;
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_bit_cnt  <= 3'd0;
            r_shift_in <= 7'd0;
            r_miso_sh  <= 8'h00;
            r_addr     <= '0;
            r_wr       <= 1'b0;
        end else if (r_state == IDLE || w_ss_n) begin
            r_bit_cnt  <= 3'd0;
            r_shift_in <= 7'd0;
            r_miso_sh  <= w_ss_n ? 8'h00 : r_regs[STATUS_ADDR];
        end else begin
            if (w_sclk_rise) begin
                r_shift_in <= w_byte[6:0];
                r_bit_cnt  <= r_bit_cnt + 3'd1;
            end else if (w_sclk_fall && r_bit_cnt != 3'd0) begin
                // Fall right after a byte boundary must keep the freshly loaded MSB
                r_miso_sh <= {r_miso_sh[6:0], 1'b0};
            end
            if (w_byte_done) begin
                if (r_state == CMD) begin
                    r_addr    <= w_cmd_addr;
                    r_wr      <= w_byte[CMD_WR_BIT];
                    r_miso_sh <= w_byte[CMD_WR_BIT] ? 8'h00 : r_regs[w_cmd_addr];
                end else begin
                    r_addr    <= w_addr_next;
                    r_miso_sh <= r_wr ? 8'h00 : r_regs[w_addr_next];
                end
            end
        end
    end

    // SPI write takes priority over a same-address fabric write
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= RESET_VAL;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (w_spi_we && r_addr == ADDR_W'(i))
                    r_regs[i] <= w_byte;
                else if (fab_we && fab_addr == ADDR_W'(i))
                    r_regs[i] <= fab_wdata;
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_fab_rdata <= 8'h00;
            r_wr_stb    <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= 8'h00;
        end else begin
            if (w_spi_we && r_addr == fab_addr) r_fab_rdata <= w_byte;
            else if (fab_we)                    r_fab_rdata <= fab_wdata;
            else                                r_fab_rdata <= r_regs[fab_addr];
            r_wr_stb <= w_spi_we;
            if (w_spi_we) begin
                r_wr_addr <= r_addr;
                r_wr_data <= w_byte;
            end
        end
    end

    assign spi_miso_oe = ~w_ss_n;
    assign spi_miso    = ~w_ss_n & r_miso_sh[7];
    assign fab_rdata   = r_fab_rdata;
    assign spi_wr_stb  = r_wr_stb;
    assign spi_wr_addr = r_wr_addr;
    assign spi_wr_data = r_wr_data;

endmodule

`default_nettype wire

// File: tb/tb_spi_target_regs.sv
// ============================================================================
// Module      : tb_spi_target_regs
// Description : Self-checking bench for spi_target_regs (directed table plus
//               randomized transfers against a register-array reference model).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_target_regs;

    logic       clk_clk = 1'b0;
    logic       reset_reset = 1'b1;
    logic       spi_sclk = 1'b0;
    logic       spi_mosi = 1'b0;
    logic       spi_ss_n = 1'b1;
    logic       spi_miso;
    logic       spi_miso_oe;
    logic [4:0] fab_addr = 5'd0;
    logic [7:0] fab_wdata = 8'h00;
    logic       fab_we = 1'b0;
    logic [7:0] fab_rdata;
    logic       spi_wr_stb;
    logic [4:0] spi_wr_addr;
    logic [7:0] spi_wr_data;

    spi_target_regs dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset),
        .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_ss_n(spi_ss_n),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .fab_addr(fab_addr), .fab_wdata(fab_wdata), .fab_we(fab_we),
        .fab_rdata(fab_rdata),
        .spi_wr_stb(spi_wr_stb), .spi_wr_addr(spi_wr_addr), .spi_wr_data(spi_wr_data)
    );

    always #5 clk_clk = ~clk_clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  model [32];
    logic [12:0] stb_q [$];
    logic [7:0]  tx_buf [5];
    logic [7:0]  rx_buf [5];

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] d0, d1;
        logic [7:0] rx0, rx1, rx2;
        logic [4:0] chk_addr;
        logic [7:0] chk_val;
    } vec_t;
    vec_t vecs [5];

    always @(negedge clk_clk) begin
        if (spi_wr_stb === 1'b1) stb_q.push_back({spi_wr_addr, spi_wr_data});
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk_clk);
    endtask

    task automatic fab_write(input logic [4:0] a, input logic [7:0] d);
        fab_addr = a; fab_wdata = d; fab_we = 1'b1;
        wait_clk(1);
        fab_we = 1'b0;
        model[a] = d;
    endtask

    task automatic fab_read(input logic [4:0] a, output logic [7:0] v);
        fab_addr = a; fab_we = 1'b0;
        wait_clk(1);
        v = fab_rdata;
    endtask

    // One SCLK half period is 8 system clocks; optional fabric write lands in
    // the cycle the synced 8th rise commits the SPI write.
    task automatic spi_byte(input logic [7:0] tx, input int nbits, input bit collide,
                            input logic [4:0] caddr, input logic [7:0] cdata,
                            output logic [7:0] rx);
        rx = 8'h00;
        for (int b = 7; b >= 8 - nbits; b--) begin
            spi_mosi = tx[b];
            wait_clk(8);
            rx[b] = spi_miso;
            spi_sclk = 1'b1;
            if (collide && b == 0) begin
                wait_clk(2);
                fab_addr = caddr; fab_wdata = cdata; fab_we = 1'b1;
                wait_clk(1);
                fab_we = 1'b0;
                wait_clk(5);
            end else begin
                wait_clk(8);
            end
            spi_sclk = 1'b0;
        end
    endtask

    task automatic spi_begin();
        spi_ss_n = 1'b0;
        wait_clk(8);
    endtask

    task automatic spi_end();
        wait_clk(4);
        spi_ss_n = 1'b1;
        wait_clk(8);
    endtask

    // Full transfer of tx_buf[0..ndata]; expectations come from the model array
    task automatic do_xfer(input int ndata, input bit collide,
                           input logic [4:0] caddr, input logic [7:0] cdata);
        logic [7:0] rx;
        logic [7:0] exp_rx;
        logic [4:0] a;
        logic [4:0] a0;
        bit         wr;
        stb_q.delete();
        a  = tx_buf[0][7:3];
        a0 = a;
        wr = tx_buf[0][1];
        spi_begin();
        spi_byte(tx_buf[0], 8, 1'b0, 5'd0, 8'h00, rx);
        rx_buf[0] = rx;
        chk("cmd_miso", {24'd0, rx}, {24'd0, model[0]});
        for (int k = 1; k <= ndata; k++) begin
            exp_rx = wr ? 8'h00 : model[a];
            spi_byte(tx_buf[k], 8, collide && (k == ndata), caddr, cdata, rx);
            rx_buf[k] = rx;
            chk("data_miso", {24'd0, rx}, {24'd0, exp_rx});
            if (collide && k == ndata) model[caddr] = cdata;
            if (wr) model[a] = tx_buf[k];
            a = a + 5'd1;
        end
        spi_end();
        chk("stb_count", 32'(stb_q.size()), wr ? 32'(ndata) : 32'd0);
        if (wr) begin
            for (int i = 0; i < stb_q.size() && i < ndata; i++)
                chk("stb_addr_data", {19'd0, stb_q[i]}, {19'd0, a0 + 5'(i), tx_buf[i + 1]});
        end
    endtask

    initial begin
        logic [7:0] v;
        logic [7:0] rx;
        int         nd;

        for (int i = 0; i < 32; i++) model[i] = 8'h00;

        vecs[0] = '{8'h10, 8'h00, 8'h00, 8'hA5, 8'h3C, 8'h00, 5'd2,  8'h3C};
        vecs[1] = '{8'h2A, 8'h11, 8'h22, 8'hA5, 8'h00, 8'h00, 5'd6,  8'h22};
        vecs[2] = '{8'h2D, 8'h00, 8'h00, 8'hA5, 8'h11, 8'h22, 5'd5,  8'h11};
        vecs[3] = '{8'hFA, 8'h01, 8'h02, 8'hA5, 8'h00, 8'h00, 5'd31, 8'h01};
        vecs[4] = '{8'hF8, 8'h00, 8'h00, 8'h02, 8'h01, 8'h02, 5'd0,  8'h02};

        // Reset state
        wait_clk(5);
        reset_reset = 1'b0;
        fab_addr = 5'd0;
        wait_clk(1);
        chk("rst_fab_rdata", {24'd0, fab_rdata}, 32'h00);
        chk("rst_oe",        {31'd0, spi_miso_oe}, 32'd0);
        chk("rst_miso",      {31'd0, spi_miso}, 32'd0);
        chk("rst_stb",       {31'd0, spi_wr_stb}, 32'd0);
        chk("rst_wr_addr",   {27'd0, spi_wr_addr}, 32'd0);
        chk("rst_wr_data",   {24'd0, spi_wr_data}, 32'd0);

        // Preload; fab_rdata reflects the write made in the previous cycle
        fab_write(5'd0, 8'hA5);
        chk("fab_rdata_after_write", {24'd0, fab_rdata}, 32'hA5);
        fab_write(5'd2, 8'h3C);

        // Directed table
        for (int t = 0; t < 5; t++) begin
            tx_buf[0] = vecs[t].cmd;
            tx_buf[1] = vecs[t].d0;
            tx_buf[2] = vecs[t].d1;
            do_xfer(2, 1'b0, 5'd0, 8'h00);
            chk("vec_rx0", {24'd0, rx_buf[0]}, {24'd0, vecs[t].rx0});
            chk("vec_rx1", {24'd0, rx_buf[1]}, {24'd0, vecs[t].rx1});
            chk("vec_rx2", {24'd0, rx_buf[2]}, {24'd0, vecs[t].rx2});
            fab_read(vecs[t].chk_addr, v);
            chk("vec_reg", {24'd0, v}, {24'd0, vecs[t].chk_val});
        end

        // Abort after 4 data bits: nothing written, no strobe
        stb_q.delete();
        spi_begin();
        spi_byte(8'h4A, 8, 1'b0, 5'd0, 8'h00, rx);
        spi_byte(8'hFF, 4, 1'b0, 5'd0, 8'h00, rx);
        spi_end();
        chk("abort_stb", 32'(stb_q.size()), 32'd0);
        fab_read(5'd9, v);
        chk("abort_reg9", {24'd0, v}, 32'h00);
        tx_buf[0] = 8'h48; tx_buf[1] = 8'h00;
        do_xfer(1, 1'b0, 5'd0, 8'h00);
        tx_buf[0] = 8'h4A; tx_buf[1] = 8'h5E;
        do_xfer(1, 1'b0, 5'd0, 8'h00);
        fab_read(5'd9, v);
        chk("after_abort_reg9", {24'd0, v}, 32'h5E);

        // Same-cycle collisions
        tx_buf[0] = 8'h1A; tx_buf[1] = 8'h77;
        do_xfer(1, 1'b1, 5'd3, 8'h55);
        fab_read(5'd3, v);
        chk("collide_same_reg3", {24'd0, v}, 32'h77);
        fab_write(5'd3, 8'h00);
        do_xfer(1, 1'b1, 5'd4, 8'h55);
        fab_read(5'd3, v);
        chk("collide_diff_reg3", {24'd0, v}, 32'h77);
        fab_read(5'd4, v);
        chk("collide_diff_reg4", {24'd0, v}, 32'h55);

        // Randomized transfers with interleaved fabric writes
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 1) == 1)
                fab_write(5'($urandom_range(0, 31)), 8'($urandom));
            nd = $urandom_range(1, 4);
            for (int k = 0; k < 5; k++) tx_buf[k] = 8'($urandom);
            do_xfer(nd, 1'b0, 5'd0, 8'h00);
        end
        for (int i = 0; i < 32; i++) begin
            fab_read(5'(i), v);
            chk("final_sweep", {24'd0, v}, {24'd0, model[i]});
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
